// File: rtl/stepper_move_controller_pkg.sv
// Shared types and phase tables for the stepper move controller.
// Optional build macro: STEPPER_HALFSTEP_EN (8-entry half-step table, 3-bit phase index).
package stepper_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ABORT    = 2'b01;
  localparam logic [1:0] ST_LIMIT    = 2'b10;

`ifdef STEPPER_HALFSTEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  // Two-phase-on full-step sequence, coil order {D,C,B,A}.
  function automatic logic [3:0] full_phase(input logic [1:0] i);
    logic [3:0] p;
    case (i)
      2'd0:    p = 4'b0011;
      2'd1:    p = 4'b0110;
      2'd2:    p = 4'b1100;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Half-step sequence; odd entries coincide with the full-step table.
  function automatic logic [3:0] half_phase(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] phase_of(input logic [IDX_W-1:0] i);
`ifdef STEPPER_HALFSTEP_EN
    return half_phase(i);
`else
    return full_phase(i);
`endif
  endfunction

endpackage

// File: rtl/stepper_move_controller_if.sv
// Command channel of the stepper move controller.
// Optional build macro: STEPPER_HALFSTEP_EN adds the half_mode field.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the master holds the payload stable while
// cmd_valid is high, and cmd_ready never depends on cmd_valid.
interface stepper_move_controller_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_period;
`ifdef STEPPER_HALFSTEP_EN
  logic             half_mode;

  modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, half_mode,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_steps, cmd_dir, cmd_period, half_mode,
                  output cmd_ready);
`else
  modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
                  output cmd_ready);
`endif
endinterface

// File: rtl/stepper_move_controller_step_rate_timer.sv
// Step period down-counter: tick is high for the one cycle where the
// count sits at 1, so a load of N yields a tick N cycles later.
module step_rate_timer #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tick
);
  logic [DIV_W-1:0] count;

  assign tick = en && (count == DIV_W'(1));

  // Load has priority so a step can reload the period on its own tick.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                   count <= '0;
    else if (load)                 count <= load_val;
    else if (en && (count != '0))  count <= count - DIV_W'(1);
  end
endmodule

// File: rtl/stepper_move_controller.sv
// Stepper move controller: accepts one move command, times the steps,
// walks the phase table onto the coils and reports how the move ended.
// Optional build macro: STEPPER_HALFSTEP_EN (half_mode input, 8-entry table).
module stepper_move_controller
  import stepper_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 20,
  parameter int IDLE_HOLD = 1
) (
  input  logic        clk,
  input  logic        resetb,
  stepper_move_controller_if.slave cmd,
  input  logic        abort,
  input  logic        limit_n,
  output logic [3:0]  coil,
  output logic        step_pulse,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_status,
  output state_t      fsm_state
);
  state_t           state, next_state;
  logic [IDX_W-1:0] idx, idx_next, inc;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] period_r, cmd_eff, load_val;
  logic             dir_r, accept, step, tick, load_timer;
  logic [1:0]       status_next;
`ifdef STEPPER_HALFSTEP_EN
  logic             half_r;
`endif

  assign fsm_state  = state;
  assign cmd_eff    = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
  assign load_timer = accept || step;
  assign load_val   = accept ? cmd_eff : period_r;

`ifdef STEPPER_HALFSTEP_EN
  assign inc = half_r ? IDX_W'(1) : IDX_W'(2);
`else
  assign inc = IDX_W'(1);
`endif

  step_rate_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .resetb   (resetb),
    .load     (load_timer),
    .load_val (load_val),
    .en       (state == S_RUN),
    .tick     (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next state, step decision and ending status; abort outranks limit and step.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    step        = 1'b0;
    status_next = done_status;
    case (state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          accept = 1'b1;
          if (cmd.cmd_steps == '0) begin
            next_state  = S_DONE;
            status_next = ST_COMPLETE;
          end else begin
            next_state  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state  = S_DONE;
          status_next = ST_ABORT;
        end else if (tick) begin
          if (!limit_n) begin
            next_state  = S_DONE;
            status_next = ST_LIMIT;
          end else begin
            step = 1'b1;
            if (remaining == CNT_W'(1)) begin
              next_state  = S_DONE;
              status_next = ST_COMPLETE;
            end
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Phase index: optional snap to a two-phase-on entry at start, then step up or down.
  always_comb begin
    idx_next = idx;
`ifdef STEPPER_HALFSTEP_EN
    if (accept && (next_state == S_RUN) && !cmd.half_mode)
      idx_next = idx | IDX_W'(1);
`endif
    if (step)
      idx_next = dir_r ? (idx + inc) : (idx - inc);
  end

  // Move context, counters and registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      idx           <= '0;
      remaining     <= '0;
      period_r      <= DIV_W'(1);
      dir_r         <= 1'b0;
`ifdef STEPPER_HALFSTEP_EN
      half_r        <= 1'b0;
`endif
      coil          <= 4'b0000;
      step_pulse    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      done_status   <= ST_COMPLETE;
      cmd.cmd_ready <= 1'b1;
    end else begin
      idx <= idx_next;
      if (accept) begin
        remaining <= cmd.cmd_steps;
        dir_r     <= cmd.cmd_dir;
        period_r  <= cmd_eff;
`ifdef STEPPER_HALFSTEP_EN
        half_r    <= cmd.half_mode;
`endif
      end else if (step) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (next_state == S_RUN)  coil <= phase_of(idx_next);
      else if (IDLE_HOLD == 0)  coil <= 4'b0000;
      else if (step)            coil <= phase_of(idx_next);
      step_pulse    <= step;
      busy          <= (next_state == S_RUN);
      done          <= (next_state == S_DONE);
      done_status   <= status_next;
      cmd.cmd_ready <= (next_state == S_IDLE);
    end
  end
endmodule
